ps2_keyboard_rx: RTL



---
 rtl/ps2_pkg.sv | 22 ++
 rtl/ps2_sync_filter.sv | 73 +++++++
 rtl/ps2_keyboard_rx.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/ps2_pkg.sv
// ============================================================================
// Module  : ps2_pkg
// Brief   : Shared receiver state encoding and PS/2 prefix byte constants.
// Revision: 1.0
// ============================================================================
`default_nettype none

package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } ps2_state_e;

  localparam logic [7:0] PS2_EXT_PREFIX   = 8'hE0;
  localparam logic [7:0] PS2_BREAK_PREFIX = 8'hF0;

endpackage

`default_nettype wire

// File: rtl/ps2_sync_filter.sv
// ============================================================================
// Module  : ps2_sync_filter
// Brief   : 2-flop synchronizer, optional debounce (PS2_RX_FILTER_EN) and a
//           registered falling-edge strobe for the PS/2 clock line.
// Revision: 1.0
// ============================================================================
`default_nettype none

module ps2_sync_filter #(
  parameter int FILTER_LEN = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic ps2_i,
  output logic fall_o
);

  logic [1:0] sync_q;
  logic       level_w;
  logic       prev_q;
  logic       fall_q;

  // Idle-high reset values keep reset itself from looking like a falling edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], ps2_i};
    end
  end

`ifdef PS2_RX_FILTER_EN
  localparam int FCW = (FILTER_LEN > 2) ? $clog2(FILTER_LEN) : 1;

  logic           filt_q;
  logic [FCW-1:0] fcnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      filt_q <= 1'b1;
      fcnt_q <= '0;
    end else if (sync_q[1] == filt_q) begin
      fcnt_q <= '0;
    end else if (fcnt_q == FCW'(FILTER_LEN - 1)) begin
      filt_q <= sync_q[1];
      fcnt_q <= '0;
    end else begin
      fcnt_q <= fcnt_q + 1'b1;
    end
  end

  assign level_w = filt_q;
`else
  if (FILTER_LEN >= 0) begin : g_no_filter
    assign level_w = sync_q[1];
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      prev_q <= 1'b1;
      fall_q <= 1'b0;
    end else begin
      prev_q <= level_w;
      fall_q <= prev_q & ~level_w;
    end
  end

  assign fall_o = fall_q;

endmodule

`default_nettype wire

// File: rtl/ps2_keyboard_rx.sv
// ============================================================================
// Module  : ps2_keyboard_rx
// Brief   : PS/2 frame receiver with E0/F0 prefix folding into key events.
//           Define PS2_RX_FILTER_EN to debounce ps2_clk before edge detection.
// Revision: 1.0
// ============================================================================
`default_nettype none

module ps2_keyboard_rx
  import ps2_pkg::*;
#(
  parameter int TIMEOUT    = 4096,
  parameter int FILTER_LEN = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_err,
  output logic [7:0] key_code,
  output logic       key_extended,
  output logic       key_release,
  output logic       key_valid,
  output logic       busy
);

  localparam int             TW       = $clog2(TIMEOUT);
  localparam logic [TW-1:0]  TMO_LAST = TW'(TIMEOUT - 1);

  logic          fall_w;
  logic [1:0]    dsync_q;
  logic          data_w;
  ps2_state_e    state_q;
  logic [2:0]    bit_cnt_q;
  logic [7:0]    shreg_q;
  logic          par_q;
  logic [TW-1:0] tmo_q;
  logic [TW-1:0] tmo_d;
  logic [7:0]    rx_data_q;
  logic          rx_valid_q;
  logic          rx_err_q;
  logic [7:0]    key_code_q;
  logic          key_ext_q;
  logic          key_rel_q;
  logic          key_valid_q;
  logic          ext_pend_q;
  logic          rel_pend_q;

  ps2_sync_filter #(
    .FILTER_LEN (FILTER_LEN)
  ) u_clk_sync (
    .clk    (clk),
    .reset  (reset),
    .ps2_i  (ps2_clk),
    .fall_o (fall_w)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      dsync_q <= 2'b11;
    end else begin
      dsync_q <= {dsync_q[0], ps2_data};
    end
  end

  assign data_w = dsync_q[1];
  assign tmo_d  = tmo_q + 1'b1;

  // A fall always takes priority over the timeout and restarts the counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      shreg_q    <= '0;
      par_q      <= 1'b0;
      tmo_q      <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      rx_err_q   <= 1'b0;
    end else begin
      rx_valid_q <= 1'b0;
      rx_err_q   <= 1'b0;
      if (fall_w) begin
        tmo_q <= '0;
        case (state_q)
          IDLE: begin
            if (!data_w) begin
              state_q   <= DATA;
              bit_cnt_q <= '0;
            end
          end
          DATA: begin
            shreg_q   <= {data_w, shreg_q[7:1]};
            bit_cnt_q <= bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) state_q <= PARITY;
          end
          PARITY: begin
            par_q   <= data_w;
            state_q <= STOP;
          end
          STOP: begin
            if (data_w && (^{shreg_q, par_q})) begin
              rx_data_q  <= shreg_q;
              rx_valid_q <= 1'b1;
            end else begin
              rx_err_q <= 1'b1;
            end
            state_q <= IDLE;
          end
          default: state_q <= IDLE;
        endcase
      end else if (state_q == IDLE) begin
        tmo_q <= '0;
      end else if (tmo_d == TMO_LAST) begin
        tmo_q    <= '0;
        state_q  <= IDLE;
        rx_err_q <= 1'b1;
      end else begin
        tmo_q <= tmo_d;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      key_code_q  <= '0;
      key_ext_q   <= 1'b0;
      key_rel_q   <= 1'b0;
      key_valid_q <= 1'b0;
      ext_pend_q  <= 1'b0;
      rel_pend_q  <= 1'b0;
    end else begin
      key_valid_q <= 1'b0;
      if (rx_err_q) begin
        ext_pend_q <= 1'b0;
        rel_pend_q <= 1'b0;
      end else if (rx_valid_q) begin
        if (rx_data_q == PS2_EXT_PREFIX) begin
          ext_pend_q <= 1'b1;
        end else if (rx_data_q == PS2_BREAK_PREFIX) begin
          rel_pend_q <= 1'b1;
        end else begin
          key_code_q  <= rx_data_q;
          key_ext_q   <= ext_pend_q;
          key_rel_q   <= rel_pend_q;
          key_valid_q <= 1'b1;
          ext_pend_q  <= 1'b0;
          rel_pend_q  <= 1'b0;
        end
      end
    end
  end

  assign rx_data      = rx_data_q;
  assign rx_valid     = rx_valid_q;
  assign rx_err       = rx_err_q;
  assign key_code     = key_code_q;
  assign key_extended = key_ext_q;
  assign key_release  = key_rel_q;
  assign key_valid    = key_valid_q;
  assign busy         = (state_q != IDLE);

endmodule

`default_nettype wire
